operand_fetch: RTL and testbench

- Operand-fetch/issue stage directly upstream of the 16-bit ALU. Supplies the ALU's A, B and ALU_Sel inputs.
- Holds an 8x16 register file and accepts decoded instructions over a valid/ready handshake.
- Tracks registers awaiting writeback in a scoreboard, stalls RAW/WAW hazards, and presents operands in a registered output slot.
- The ALU result returns through the writeback port, fed by downstream logic.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/operand_fetch_if.sv | 38 +++
 rtl/op_regfile.sv | 31 +++
 rtl/operand_fetch.sv | 110 +++++++++++
 tb/tb_operand_fetch.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizes for the ALU operand-fetch slice.
// Exports alu_sel_t and DATA_W / NREGS / RA_W.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int RA_W   = 3;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_CLR  = 2'b11
   } alu_sel_t;

   // Which operand slots an op actually reads
   function automatic logic uses_a(alu_sel_t s);
      return s != ALU_CLR;
   endfunction

   function automatic logic uses_b(alu_sel_t s);
      return (s == ALU_ADD) || (s == ALU_SUB);
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue bus: decoded-instruction handshake, operand slot, writeback.
// slave = operand_fetch side, master = decode/ALU/writeback side.
interface operand_fetch_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_sel;
   logic [RA_W-1:0]   in_rs1;
   logic [RA_W-1:0]   in_rs2;
   logic [RA_W-1:0]   in_rd;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [1:0]        out_sel;
   logic [RA_W-1:0]   out_rd;

   logic              wb_en;
   logic [RA_W-1:0]   wb_addr;
   logic [DATA_W-1:0] wb_data;

   modport slave (
      input  in_valid, in_sel, in_rs1, in_rs2, in_rd,
      input  out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, out_a, out_b,
      output out_sel, out_rd
   );

   modport master (
      output in_valid, in_sel, in_rs1, in_rs2, in_rd,
      output out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, out_a, out_b,
      input  out_sel, out_rd
   );

endinterface

// File: rtl/op_regfile.sv
// NREGS x DATA_W register file: 2 comb read ports, 1 sync write.
// Ports: clk, rst_n (async clear), we/waddr/wdata, ra_a/ra_b -> rd_a/rd_b.
module op_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   ra_a,
   input  logic [RA_W-1:0]   ra_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rd_a = mem[ra_a];
   assign rd_b = mem[ra_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch/issue: regfile, busy scoreboard, registered ALU slot.
// Ports: clk, rst_n, bus (operand_fetch_if.slave). OPERAND_FWD_EN: wb bypass.
module operand_fetch
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   operand_fetch_if.slave  bus
);

   alu_sel_t          sel;
   logic              use_a;
   logic              use_b;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   logic [NREGS-1:0]  busy;
   logic [NREGS-1:0]  busy_eff;
   logic [NREGS-1:0]  busy_nxt;
   logic [NREGS-1:0]  wb_mask;
   logic [NREGS-1:0]  set_mask;

   logic              hazard;
   logic              accept;

   logic              s_valid;
   logic [DATA_W-1:0] s_a;
   logic [DATA_W-1:0] s_b;
   logic [1:0]        s_sel;
   logic [RA_W-1:0]   s_rd;

   assign sel   = alu_sel_t'(bus.in_sel);
   assign use_a = uses_a(sel);
   assign use_b = uses_b(sel);

   op_regfile u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.wb_en),
      .waddr (bus.wb_addr),
      .wdata (bus.wb_data),
      .ra_a  (bus.in_rs1),
      .ra_b  (bus.in_rs2),
      .rd_a  (rd_a),
      .rd_b  (rd_b)
   );

   assign wb_mask  = bus.wb_en ?
                     (NREGS'(1) << bus.wb_addr) : '0;
   assign set_mask = NREGS'(1) << bus.in_rd;

`ifdef OPERAND_FWD_EN
   // A register retiring this cycle is already safe to read:
   // its value comes straight off the writeback bus.
   assign busy_eff = busy & ~wb_mask;
   assign opnd_a = (bus.wb_en && bus.wb_addr == bus.in_rs1) ?
                   bus.wb_data : rd_a;
   assign opnd_b = (bus.wb_en && bus.wb_addr == bus.in_rs2) ?
                   bus.wb_data : rd_b;
`else
   assign busy_eff = busy;
   assign opnd_a   = rd_a;
   assign opnd_b   = rd_b;
`endif

   assign hazard = (use_a && busy_eff[bus.in_rs1])
                || (use_b && busy_eff[bus.in_rs2])
                || busy_eff[bus.in_rd];

   assign bus.in_ready = (!s_valid || bus.out_ready) && !hazard;
   assign accept       = bus.in_valid && bus.in_ready;

   // Set after clear: an issuing rd wins over a retiring one
   assign busy_nxt = (busy & ~wb_mask)
                   | (accept ? set_mask : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid <= 1'b0;
         s_a     <= '0;
         s_b     <= '0;
         s_sel   <= '0;
         s_rd    <= '0;
      end else if (accept) begin
         s_valid <= 1'b1;
         s_a     <= opnd_a;
         s_b     <= opnd_b;
         s_sel   <= bus.in_sel;
         s_rd    <= bus.in_rd;
      end else if (bus.out_ready) begin
         s_valid <= 1'b0;
      end
   end

   assign bus.out_valid = s_valid;
   assign bus.out_a     = s_a;
   assign bus.out_b     = s_b;
   assign bus.out_sel   = s_sel;
   assign bus.out_rd    = s_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus
// random traffic against a behavioural register/scoreboard model.
module tb_operand_fetch;
   import alu_pkg::*;

`ifdef OPERAND_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_reg [8];
   bit          m_busy [8];
   bit          m_ov;
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [1:0]  m_sel;
   logic [2:0]  m_rd;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 8; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_ov  = 1'b0;
      m_a   = '0;
      m_b   = '0;
      m_sel = '0;
      m_rd  = '0;
   endfunction

   // A register blocks issue if it awaits writeback, unless
   // forwarding is built in and it retires in this very cycle.
   function automatic bit blocks(logic [2:0] r, bit we,
                                 logic [2:0] wa);
      return m_busy[r] && !(FWD && we && wa == r);
   endfunction

   function automatic bit m_ready(logic [1:0] s,
                                  logic [2:0] r1,
                                  logic [2:0] r2,
                                  logic [2:0] rd,
                                  bit ordy, bit we,
                                  logic [2:0] wa);
      bit haz;
      haz = blocks(rd, we, wa);
      if (s != 2'b11 && blocks(r1, we, wa))
         haz = 1'b1;
      if ((s == 2'b01 || s == 2'b10) && blocks(r2, we, wa))
         haz = 1'b1;
      return (!m_ov || ordy) && !haz;
   endfunction

   task automatic check_outs();
      check("out_valid", bus.out_valid, m_ov);
      check("out_a", bus.out_a, m_a);
      check("out_b", bus.out_b, m_b);
      check("out_sel", bus.out_sel, m_sel);
      check("out_rd", bus.out_rd, m_rd);
   endtask

   // One clock: drive, check in_ready, advance model, check slot
   task automatic step(input bit v, input logic [1:0] s,
                       input logic [2:0] r1,
                       input logic [2:0] r2,
                       input logic [2:0] rd,
                       input bit ordy, input bit we,
                       input logic [2:0] wa,
                       input logic [15:0] wd,
                       output bit acc);
      bit rdy;
      logic [15:0] na;
      logic [15:0] nb;
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_rs1    = r1;
      bus.in_rs2    = r2;
      bus.in_rd     = rd;
      bus.out_ready = ordy;
      bus.wb_en     = we;
      bus.wb_addr   = wa;
      bus.wb_data   = wd;
      #1;
      rdy = m_ready(s, r1, r2, rd, ordy, we, wa);
      check("in_ready", bus.in_ready, rdy);
      acc = v && rdy;
      na = (FWD && we && wa == r1) ? wd : m_reg[r1];
      nb = (FWD && we && wa == r2) ? wd : m_reg[r2];
      @(posedge clk);
      if (we) begin
         m_reg[wa]  = wd;
         m_busy[wa] = 1'b0;
      end
      if (acc) begin
         m_ov  = 1'b1;
         m_a   = na;
         m_b   = nb;
         m_sel = s;
         m_rd  = rd;
         m_busy[rd] = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      @(negedge clk);
      check_outs();
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
   endtask

   // Retire every outstanding destination, keeping its value
   task automatic wb_clean();
      bit a;
      for (int i = 0; i < 8; i++)
         if (m_busy[i])
            step(0, 0, 0, 0, 0, 1, 1, 3'(i), m_reg[i], a);
   endtask

   bit a;
   bit any;
   logic [2:0] wa;

   initial begin
      rst_n = 1'b0;
      bus.in_valid  = 0;
      bus.in_sel    = 0;
      bus.in_rs1    = 0;
      bus.in_rs2    = 0;
      bus.in_rd     = 0;
      bus.out_ready = 0;
      bus.wb_en     = 0;
      bus.wb_addr   = 0;
      bus.wb_data   = 0;
      m_reset();
      repeat (2) @(negedge clk);
      check_outs();
      rst_n = 1'b1;

      // 1: ADD r3=r1+r2, then dependent SUB r4=r3-r1
      step(0, 0, 0, 0, 0, 1, 1, 1, 16'h0005, a);
      step(0, 0, 0, 0, 0, 1, 1, 2, 16'h0003, a);
      step(1, 1, 1, 2, 3, 1, 0, 0, 0, a);
      check("t1_add_acc", a, 1);
      check("t1_add_a", bus.out_a, 16'h0005);
      check("t1_add_b", bus.out_b, 16'h0003);
      check("t1_add_sel", bus.out_sel, 2'b01);
      check("t1_add_rd", bus.out_rd, 3);
      step(1, 2, 3, 1, 4, 1, 0, 0, 0, a);
      check("t1_raw_stall", a, 0);
      step(1, 2, 3, 1, 4, 1, 1, 3, 16'h0008, a);
      check("t1_wb_cycle_acc", a, FWD);
      if (!a) begin
         step(1, 2, 3, 1, 4, 1, 0, 0, 0, a);
         check("t1_late_acc", a, 1);
      end
      check("t1_sub_a", bus.out_a, 16'h0008);
      check("t1_sub_b", bus.out_b, 16'h0005);
      wb_clean();

      // 2: WAW on r6
      step(1, 0, 5, 0, 6, 1, 0, 0, 0, a);
      check("t2_acc", a, 1);
      step(1, 0, 0, 0, 6, 1, 0, 0, 0, a);
      check("t2_waw_stall", a, 0);
      step(1, 0, 0, 0, 6, 1, 1, 6, 16'h1234, a);
      check("t2_wb_cycle_acc", a, FWD);
      if (!a) begin
         step(1, 0, 0, 0, 6, 1, 0, 0, 0, a);
         check("t2_late_acc", a, 1);
      end
      wb_clean();

      // 3: clear op ignores busy sources
      step(1, 1, 0, 0, 1, 1, 0, 0, 0, a);
      step(1, 3, 1, 1, 2, 1, 0, 0, 0, a);
      check("t3_clr_acc", a, 1);
      check("t3_clr_sel", bus.out_sel, 2'b11);
      wb_clean();

      // 4: backpressure then back-to-back
      step(1, 1, 1, 2, 5, 0, 0, 0, 0, a);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 2, 3, 6, 0, 0, 0, 0, a);
         check("t4_hold_stall", a, 0);
      end
      step(1, 1, 2, 3, 6, 1, 0, 0, 0, a);
      check("t4_b2b_0", a, 1);
      step(1, 2, 2, 3, 7, 1, 0, 0, 0, a);
      check("t4_b2b_1", a, 1);
      wb_clean();

      // 5: async reset while r2 is busy and the slot is held
      step(0, 0, 0, 0, 0, 1, 1, 2, 16'hBEEF, a);
      step(1, 1, 0, 0, 2, 0, 0, 0, 0, a);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 2, 0, 5, 1, 0, 0, 0, a);
      check("t5_post_rst_acc", a, 1);
      check("t5_r2_cleared", bus.out_a, 16'h0000);
      wb_clean();

      // 6: all-ones operands and r0 writeback
      step(0, 0, 0, 0, 0, 1, 1, 7, 16'hFFFF, a);
      step(1, 1, 7, 7, 0, 1, 0, 0, 0, a);
      check("t6_a", bus.out_a, 16'hFFFF);
      check("t6_b", bus.out_b, 16'hFFFF);
      check("t6_sel", bus.out_sel, 2'b01);
      step(0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFE, a);
      step(1, 0, 0, 0, 1, 1, 0, 0, 0, a);
      check("t6_r0", bus.out_a, 16'hFFFE);
      wb_clean();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         any = 1'b0;
         wa  = 3'($urandom);
         for (int k = 0; k < 8; k++)
            if (!any && m_busy[(int'(wa) + k) % 8]) begin
               any = 1'b1;
               wa  = 3'((int'(wa) + k) % 8);
            end
         step($urandom_range(0, 3) != 0,
              2'($urandom),
              3'($urandom), 3'($urandom), 3'($urandom),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1,
              wa, 16'($urandom), a);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
